// File: rtl/host_loader_pkg.sv
// Shared types for the host command loader: command kind, FSM state and FIFO entry.
package host_loader_pkg;

  typedef enum logic {
    CMD_INST = 1'b0,
    CMD_ADDR = 1'b1
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } loader_state_e;

  typedef struct packed {
    cmd_e        cmd;
    logic [31:0] data;
  } loader_entry_t;

  localparam int ENTRY_W = $bits(loader_entry_t);

endpackage

// File: rtl/loader_fifo.sv
// Synchronous FIFO with flush. A push into a full FIFO is accepted only when a
// pop happens in the same cycle. Pointers wrap modulo DEPTH (power of two).
module loader_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 33,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem[rd_ptr];
  assign level_o = level_q;

  // Pointer and occupancy bookkeeping; flush wins over push/pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (clear_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage write; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem[wr_ptr] <= wdata_i;
  end

endmodule

// File: rtl/host_loader.sv
// Host command loader: queues instruction words / section addresses from the
// host and hands them one at a time to a downstream bridge, waiting for the
// bridge's busy handshake between commands. Also holds bridge readback data.
//
// Handshakes: a host write is taken on a cycle where host_we_i=1 and
// host_ready_o=1 (or the FIFO pops that same cycle); a write while full and not
// popping is dropped and flagged in overflow_o. Readback: rdata_valid_o stays
// high until the host pulses rdata_ack_i; a new obi_rvalid_i in that same cycle
// takes priority and reloads the data.
module host_loader
  import host_loader_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          host_we_i,
  input  logic                          host_cmd_i,
  input  logic [31:0]                   host_wdata_i,
  output logic                          host_ready_o,
  output logic                          inst_valid_o,
  output logic [31:0]                   instruction_o,
  output logic                          new_addr_valid_o,
  output logic [31:0]                   new_section_address_o,
  input  logic                          busy_i,
  input  logic                          obi_rvalid_i,
  input  logic [31:0]                   obi_rdata_i,
  output logic [31:0]                   rdata_o,
  output logic                          rdata_valid_o,
  input  logic                          rdata_ack_i,
  input  logic                          clear_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o,
  output logic                          timeout_o,
  output loader_state_e                 state_o
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  loader_state_e  state_q, state_d;
  logic [CW-1:0]  ack_cnt_q;
  logic           issue;
  logic           ack_timeout;
  logic           fifo_full;
  logic           fifo_empty;
  logic [ENTRY_W-1:0] fifo_rdata;
  loader_entry_t  head;
  logic [31:0]    inst_q;
  logic [31:0]    addr_q;
  logic [31:0]    rdata_q;
  logic           rvalid_q;
  logic           overflow_q;
  logic           timeout_q;

  loader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (host_we_i),
    .pop_i   (issue),
    .wdata_i ({host_cmd_i, host_wdata_i}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  assign head = loader_entry_t'(fifo_rdata);

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state, pop strobe and ack-timeout detection; a flush overrides all.
  always_comb begin
    state_d     = state_q;
    issue       = 1'b0;
    ack_timeout = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !busy_i) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        issue   = 1'b1;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (busy_i) begin
          state_d = ST_WAIT_DONE;
        end else if (ack_cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          ack_timeout = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!busy_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear_i) begin
      state_d     = ST_IDLE;
      issue       = 1'b0;
      ack_timeout = 1'b0;
    end
  end

  // Cycles spent in WAIT_ACK, restarted on every entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                    ack_cnt_q <= '0;
    else if (state_q != ST_WAIT_ACK) ack_cnt_q <= '0;
    else                            ack_cnt_q <= ack_cnt_q + CW'(1);
  end

  // Issue pulses are combinational with the pop; data outputs show the head
  // during the pulse and otherwise the last value issued on that channel.
  assign inst_valid_o          = issue && (head.cmd == CMD_INST);
  assign new_addr_valid_o      = issue && (head.cmd == CMD_ADDR);
  assign instruction_o         = inst_valid_o ? head.data : inst_q;
  assign new_section_address_o = new_addr_valid_o ? head.data : addr_q;

  // Remember the last issued payload per channel.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inst_q <= '0;
      addr_q <= '0;
    end else begin
      if (inst_valid_o)     inst_q <= head.data;
      if (new_addr_valid_o) addr_q <= head.data;
    end
  end

  // Readback holding register and sticky error flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else if (clear_i) begin
      rvalid_q   <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (host_we_i && fifo_full && !issue) overflow_q <= 1'b1;
      if (obi_rvalid_i && rvalid_q)         overflow_q <= 1'b1;
      if (ack_timeout)                      timeout_q  <= 1'b1;
      if (obi_rvalid_i) begin
        rdata_q  <= obi_rdata_i;
        rvalid_q <= 1'b1;
      end else if (rdata_ack_i) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign host_ready_o  = !fifo_full;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rvalid_q;
  assign overflow_o    = overflow_q;
  assign timeout_o     = timeout_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_host_loader.sv
// Bench for host_loader: directed scenarios plus a randomized run, all checked
// cycle by cycle against a transaction-level model (queue of pending commands,
// a simple bridge that answers with busy after a delay, readback register).
module tb_host_loader;
  import host_loader_pkg::*;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int W     = 33;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_ni;
  logic          host_we_i, host_cmd_i;
  logic [31:0]   host_wdata_i;
  logic          host_ready_o;
  logic          inst_valid_o, new_addr_valid_o;
  logic [31:0]   instruction_o, new_section_address_o;
  logic          busy_i;
  logic          obi_rvalid_i;
  logic [31:0]   obi_rdata_i;
  logic [31:0]   rdata_o;
  logic          rdata_valid_o, rdata_ack_i, clear_i;
  logic [LW-1:0] fifo_level_o;
  logic          overflow_o, timeout_o;
  loader_state_e state_o;

  always #5 clk = ~clk;

  host_loader #(.FIFO_DEPTH(DEPTH), .ACK_TIMEOUT(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .host_we_i(host_we_i), .host_cmd_i(host_cmd_i), .host_wdata_i(host_wdata_i),
    .host_ready_o(host_ready_o),
    .inst_valid_o(inst_valid_o), .instruction_o(instruction_o),
    .new_addr_valid_o(new_addr_valid_o), .new_section_address_o(new_section_address_o),
    .busy_i(busy_i),
    .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .rdata_ack_i(rdata_ack_i),
    .clear_i(clear_i), .fifo_level_o(fifo_level_o),
    .overflow_o(overflow_o), .timeout_o(timeout_o), .state_o(state_o)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [W-1:0] exp_q[$];
  int          cyc = 0;
  int          free_from, prev_size, busy_start, busy_end, tmo_at;
  bit          prev_pulse, prev_clear, prev_busy;
  bit          ovf_exp, tmo_exp, rv_exp;
  logic [31:0] rd_exp, held_inst, held_addr;
  bit          bridge_never, bridge_rand, force_busy;
  int          bridge_d, bridge_l;
  int          n_pulse = 0;
  int          first_pulse_cyc = -1;

  task automatic model_reset();
    exp_q.delete();
    ovf_exp = 0; tmo_exp = 0; rv_exp = 0;
    rd_exp = '0; held_inst = '0; held_addr = '0;
    free_from = cyc; prev_size = 0;
    prev_pulse = 0; prev_clear = 0; prev_busy = 0;
    busy_start = 0; busy_end = 0; tmo_at = -1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    host_we_i = 0; host_cmd_i = 0; host_wdata_i = '0;
    obi_rvalid_i = 0; obi_rdata_i = '0; rdata_ack_i = 0; clear_i = 0;
  endtask

  // One clock cycle: inputs already set at the falling edge. Predict this
  // cycle's outputs, compare, then advance the model across the rising edge.
  task automatic run_cycle();
    bit exp_pulse;
    bit accept;
    int size_now;
    int d, l;
    logic [W-1:0] head;
    busy_i = force_busy || (cyc >= busy_start && cyc < busy_end);
    if (cyc == tmo_at) tmo_exp = 1;
    size_now  = exp_q.size();
    // The loader issues the cycle after it sits idle (bridge released, busy low)
    // looking at a non-empty queue, unless a flush intervenes.
    exp_pulse = (cyc - 1 >= free_from) && (prev_size > 0) && !prev_pulse &&
                !prev_clear && !prev_busy && !clear_i;
    head = (size_now > 0) ? exp_q[0] : '0;
    #1;
    check_eq("fifo_level", fifo_level_o, size_now);
    check_eq("host_ready", host_ready_o, size_now < DEPTH);
    check_eq("overflow", overflow_o, ovf_exp);
    check_eq("timeout", timeout_o, tmo_exp);
    check_eq("rdata_valid", rdata_valid_o, rv_exp);
    check_eq("rdata", rdata_o, rd_exp);
    check_eq("inst_valid", inst_valid_o, exp_pulse && !head[32]);
    check_eq("addr_valid", new_addr_valid_o, exp_pulse && head[32]);
    check_eq("instruction", instruction_o, (exp_pulse && !head[32]) ? head[31:0] : held_inst);
    check_eq("section_addr", new_section_address_o, (exp_pulse && head[32]) ? head[31:0] : held_addr);
    if (inst_valid_o || new_addr_valid_o) begin
      n_pulse++;
      if (first_pulse_cyc < 0) first_pulse_cyc = cyc;
    end
    @(posedge clk);
    accept = host_we_i && ((size_now < DEPTH) || exp_pulse);
    if (clear_i) begin
      exp_q.delete();
      ovf_exp = 0; tmo_exp = 0; rv_exp = 0;
      free_from = cyc + 1; busy_start = 0; busy_end = 0; tmo_at = -1;
    end else begin
      if (exp_pulse) begin
        void'(exp_q.pop_front());
        if (head[32]) held_addr = head[31:0];
        else          held_inst = head[31:0];
        if (bridge_never) begin
          busy_start = 0; busy_end = 0;
          tmo_at = cyc + 5; free_from = cyc + 5;
        end else begin
          d = bridge_rand ? int'($urandom_range(1, 4)) : bridge_d;
          l = bridge_rand ? int'($urandom_range(1, 3)) : bridge_l;
          busy_start = cyc + d;
          busy_end   = busy_start + l;
          free_from  = busy_end + 1;
        end
      end
      if (accept)         exp_q.push_back({host_cmd_i, host_wdata_i});
      else if (host_we_i) ovf_exp = 1;
      if (obi_rvalid_i) begin
        if (rv_exp) ovf_exp = 1;
        rd_exp = obi_rdata_i;
        rv_exp = 1;
      end else if (rdata_ack_i) begin
        rv_exp = 0;
      end
    end
    prev_size  = size_now;
    prev_pulse = exp_pulse;
    prev_clear = clear_i;
    prev_busy  = busy_i;
    cyc++;
    @(negedge clk);
  endtask

  task automatic push_cycle(input logic cmd, input logic [31:0] data);
    idle_inputs();
    host_we_i = 1; host_cmd_i = cmd; host_wdata_i = data;
    run_cycle();
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) begin
      idle_inputs();
      run_cycle();
    end
  endtask

  task automatic clear_cycle();
    idle_inputs();
    clear_i = 1;
    run_cycle();
  endtask

  task automatic rvalid_cycle(input logic [31:0] data);
    idle_inputs();
    obi_rvalid_i = 1; obi_rdata_i = data;
    run_cycle();
  endtask

  task automatic check_reset_values();
    check_eq("rst_level", fifo_level_o, 0);
    check_eq("rst_ready", host_ready_o, 1);
    check_eq("rst_inst_valid", inst_valid_o, 0);
    check_eq("rst_addr_valid", new_addr_valid_o, 0);
    check_eq("rst_instruction", instruction_o, 0);
    check_eq("rst_section_addr", new_section_address_o, 0);
    check_eq("rst_rdata", rdata_o, 0);
    check_eq("rst_rdata_valid", rdata_valid_o, 0);
    check_eq("rst_overflow", overflow_o, 0);
    check_eq("rst_timeout", timeout_o, 0);
    check_eq("rst_state", state_o, ST_IDLE);
  endtask

  // Reset asserted asynchronously in the middle of the low clock phase.
  task automatic apply_reset_mid();
    idle_inputs();
    force_busy = 0;
    busy_i = 0;
    #2 rst_ni = 0;
    #1 check_reset_values();
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int c0, p0;
    rst_ni = 0;
    idle_inputs();
    busy_i = 0;
    force_busy = 0; bridge_never = 0; bridge_rand = 0;
    bridge_d = 3; bridge_l = 2;
    model_reset();
    repeat (3) @(negedge clk);
    #1 check_reset_values();
    rst_ni = 1;
    @(negedge clk);
    model_reset();
    idle_n(2);

    // Address then instruction, bridge answers 3 cycles after each issue.
    p0 = n_pulse; first_pulse_cyc = -1; c0 = cyc;
    push_cycle(1'b1, 32'h0000_1000);
    push_cycle(1'b0, 32'h0051_3023);
    idle_n(20);
    check_eq("t027_pulses", n_pulse - p0, 2);
    check_eq("t027_latency", first_pulse_cyc - c0, 2);
    check_eq("t027_last_addr", new_section_address_o, 32'h0000_1000);
    check_eq("t027_last_inst", instruction_o, 32'h0051_3023);

    // Fill while bridge busy: ninth write is dropped.
    force_busy = 1;
    for (int i = 0; i < 9; i++) push_cycle(1'($urandom_range(0, 1)), $urandom);
    #1;
    check_eq("t028_level", fifo_level_o, 8);
    check_eq("t028_ready", host_ready_o, 0);
    check_eq("t028_overflow", overflow_o, 1);
    force_busy = 0;
    idle_n(120);

    // Bridge never answers: timeout, back to idle, next entry still issued.
    bridge_never = 1;
    p0 = n_pulse;
    push_cycle(1'b0, 32'hAAAA_0001);
    push_cycle(1'b1, 32'hBBBB_0002);
    idle_n(20);
    #1;
    check_eq("t029_timeout", timeout_o, 1);
    check_eq("t029_state", state_o, ST_IDLE);
    check_eq("t029_pulses", n_pulse - p0, 2);
    bridge_never = 0;

    // Readback overwrite before ack.
    clear_cycle();
    rvalid_cycle(32'hDEAD_BEEF);
    rvalid_cycle(32'h1234_5678);
    idle_n(1);
    #1;
    check_eq("t030_rdata", rdata_o, 32'h1234_5678);
    check_eq("t030_overflow", overflow_o, 1);
    check_eq("t030_rvalid", rdata_valid_o, 1);
    idle_inputs();
    rdata_ack_i = 1;
    run_cycle();
    #1 check_eq("t030_ack", rdata_valid_o, 0);
    idle_n(2);

    // Flush with five queued while the bridge is still busy.
    bridge_d = 1; bridge_l = 40;
    for (int i = 0; i < 6; i++) push_cycle(1'($urandom_range(0, 1)), $urandom);
    rvalid_cycle(32'hCAFE_0032);
    idle_n(3);
    #1;
    check_eq("t032_pre_state", state_o, ST_WAIT_DONE);
    check_eq("t032_pre_level", fifo_level_o, 5);
    clear_cycle();
    #1;
    check_eq("t032_state", state_o, ST_IDLE);
    check_eq("t032_level", fifo_level_o, 0);
    check_eq("t032_overflow", overflow_o, 0);
    check_eq("t032_rvalid", rdata_valid_o, 0);
    idle_n(5);

    // Reset during WAIT_DONE with three queued.
    rvalid_cycle(32'h0BAD_F00D);
    for (int i = 0; i < 4; i++) push_cycle(1'($urandom_range(0, 1)), $urandom);
    idle_n(4);
    #1;
    check_eq("t031_pre_state", state_o, ST_WAIT_DONE);
    check_eq("t031_pre_level", fifo_level_o, 3);
    apply_reset_mid();
    p0 = n_pulse;
    idle_n(20);
    check_eq("t031_no_pulse", n_pulse - p0, 0);

    // Randomized traffic.
    bridge_rand = 1;
    for (int i = 0; i < 1500; i++) begin
      idle_inputs();
      host_we_i    = ($urandom_range(0, 99) < 40);
      host_cmd_i   = 1'($urandom_range(0, 1));
      host_wdata_i = $urandom;
      obi_rvalid_i = ($urandom_range(0, 99) < 15);
      obi_rdata_i  = $urandom;
      rdata_ack_i  = ($urandom_range(0, 99) < 30);
      clear_i      = ($urandom_range(0, 99) < 2);
      run_cycle();
    end
    for (int i = 0; i < 600 && exp_q.size() > 0; i++) idle_n(1);
    check_eq("drain_empty", exp_q.size(), 0);
    idle_n(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/host_loader.md
HOST_LOADER -- requirements
Module: host_loader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, command FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 4, max cycles from issue pulse to busy_i rising.
REQ-003 SHALL have ports: clk_i in 1 single clock; rst_ni in 1 reset, asynchronous, active-low.
REQ-004 SHALL have ports: host_we_i in 1 host write strobe; host_cmd_i in 1 0=instruction word, 1=section address; host_wdata_i in 32 write payload; host_ready_o out 1 FIFO not full.
REQ-005 SHALL have ports: inst_valid_o out 1, instruction_o out 32, new_addr_valid_o out 1, new_section_address_o out 32, busy_i in 1; all to the downstream bridge.
REQ-006 SHALL have ports: obi_rvalid_i in 1, obi_rdata_i in 32 bridge readback; rdata_o out 32 held readback; rdata_valid_o out 1 readback pending; rdata_ack_i in 1 host consumed readback.
REQ-007 SHALL have ports: clear_i in 1 sync flush; fifo_level_o out $clog2(FIFO_DEPTH)+1 occupancy; overflow_o out 1 sticky; timeout_o out 1 sticky.

Function
REQ-008 SHALL push {host_cmd_i, host_wdata_i} into the FIFO on host_we_i when host_ready_o=1; push visible to pop next cycle.
REQ-009 SHALL drop a write when host_we_i=1 and FIFO full and set overflow_o on the following edge.
REQ-010 SHALL accept simultaneous push and pop on a full FIFO only if pop occurs that cycle; level unchanged.
REQ-011 SHALL use FSM states IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
REQ-012 IDLE->ISSUE when FIFO non-empty and busy_i=0; otherwise stay IDLE.
REQ-013 ISSUE SHALL pop the head, drive exactly one cycle of inst_valid_o (cmd=0) or new_addr_valid_o (cmd=1) with payload on the matching data output, then go to WAIT_ACK.
REQ-014 instruction_o and new_section_address_o SHALL hold their last issued value between issues.
REQ-015 WAIT_ACK SHALL go to WAIT_DONE when busy_i=1; after ACK_TIMEOUT cycles without busy_i set timeout_o and return to IDLE.
REQ-016 WAIT_DONE SHALL return to IDLE when busy_i=0; next ISSUE at earliest the cycle after.
REQ-017 Issue latency SHALL be 2 cycles from push (empty FIFO, busy_i=0) to valid pulse.
REQ-018 SHALL capture obi_rdata_i into rdata_o and set rdata_valid_o on obi_rvalid_i, in any state.
REQ-019 rdata_valid_o SHALL clear on rdata_ack_i; new obi_rvalid_i same cycle as ack wins (stays set, new data).
REQ-020 Capture while rdata_valid_o=1 SHALL overwrite rdata_o and set overflow_o.
REQ-021 clear_i SHALL empty FIFO, clear sticky flags and rdata_valid_o, force IDLE; an in-flight bridge op is abandoned, no pulse that cycle.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; level uses one extra bit to distinguish full/empty.

Reset
REQ-023 On rst_ni=0 SHALL asynchronously force: FSM IDLE, FIFO empty, fifo_level_o=0, host_ready_o=1, inst_valid_o=0, new_addr_valid_o=0, instruction_o=0, new_section_address_o=0, rdata_o=0, rdata_valid_o=0, overflow_o=0, timeout_o=0.
REQ-024 Reset asserted mid-operation SHALL discard all queued and in-flight commands; no pulse emitted after release until a new push.

Structure
REQ-025 SHALL place the cmd-type enum, FSM state enum and 33-bit entry struct in package host_loader_pkg.
REQ-026 SHALL implement the FIFO as sub-module loader_fifo (parameterised depth/width, push/pop/full/empty/level).

Verification
REQ-027 Push cmd=1 0x0000_1000 then cmd=0 0x0051_3023, busy_i pulses 3 cycles after each issue -> new_addr_valid_o then inst_valid_o, one cycle each, payloads exact, order kept.
REQ-028 Push 9 words with busy_i held 1 -> 8 accepted, host_ready_o=0, overflow_o=1, fifo_level_o=8.
REQ-029 Issue with busy_i never rising -> timeout_o=1 after 4 cycles, FSM IDLE, next entry issued.
REQ-030 obi_rvalid_i with 0xDEAD_BEEF, then 0x1234_5678 before ack -> rdata_o=0x1234_5678, overflow_o=1; ack clears rdata_valid_o.
REQ-031 Assert rst_ni=0 in WAIT_DONE with 3 queued -> all outputs at reset values immediately; no pulses after release.
REQ-032 clear_i with 5 queued during WAIT_DONE -> level 0, flags 0, IDLE next cycle.
